phase_sequencer: RTL

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

---
 rtl/phase_sequencer_if.sv | 31 +++
 rtl/phase_sequencer.sv | 93 +++++++++
 2 files changed

// File: rtl/phase_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : phase_sequencer_if
// Brief    : Controller-to-sequencer bundle: control requests in, phase and
//            status out.
// Revision : 1.0
// ============================================================================
interface phase_sequencer_if #(
  parameter int INST_CNT_W = 16
);
  logic                  halt;
  logic                  run;
  logic                  step_en;
  logic                  step;
  logic [2:0]            phase;
  logic                  halted;
  logic                  paused;
  logic                  inst_start;
  logic [INST_CNT_W-1:0] inst_count;

  modport master (
    output halt, run, step_en, step,
    input  phase, halted, paused, inst_start, inst_count
  );

  modport slave (
    input  halt, run, step_en, step,
    output phase, halted, paused, inst_start, inst_count
  );
endinterface
`default_nettype wire

// File: rtl/phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : phase_sequencer
// Brief    : Eight-phase instruction sequencer with halt, resume and
//            single-step control plus a retired-instruction counter.
// Revision : 1.0
// ============================================================================
module phase_sequencer #(
  parameter int INST_CNT_W = 16
) (
  input  wire logic         clk,
  input  wire logic         rst,
  phase_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [2:0]            c_halt_phase   = 3'd4;
  localparam logic [2:0]            c_last_phase   = 3'd7;
  localparam logic [2:0]            c_resume_phase = 3'd5;
  localparam logic [2:0]            c_step_phase   = 3'd1;
  localparam logic [INST_CNT_W-1:0] c_cnt_one      = {{(INST_CNT_W-1){1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_state_nxt;
  logic [2:0]            r_phase;
  logic [2:0]            w_phase_nxt;
  logic [INST_CNT_W-1:0] r_inst_count;
  logic [INST_CNT_W-1:0] w_inst_count_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_phase      <= 3'd0;
      r_inst_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_phase      <= w_phase_nxt;
      r_inst_count <= w_inst_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_phase_nxt      = r_phase;
    w_inst_count_nxt = r_inst_count;
    unique case (r_state)
      ST_RUN: begin
        // Halt is only honoured at the mid-instruction phase; the phase freezes there.
        if ((r_phase == c_halt_phase) && bus.halt) begin
          w_state_nxt = ST_HALT;
        end else begin
          w_phase_nxt = r_phase + 3'd1;
          if (r_phase == c_last_phase) begin
            w_inst_count_nxt = r_inst_count + c_cnt_one;
            if (bus.step_en) begin
              w_state_nxt = ST_PAUSE;
            end
          end
        end
      end
      ST_HALT: begin
        if (bus.run) begin
          w_state_nxt = ST_RUN;
          w_phase_nxt = c_resume_phase;
        end
      end
      ST_PAUSE: begin
        // Resuming from pause skips phase 0: the boundary was already consumed.
        if (bus.run || bus.step) begin
          w_state_nxt = ST_RUN;
          w_phase_nxt = c_step_phase;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_phase_nxt = 3'd0;
      end
    endcase
  end

  assign bus.phase      = r_phase;
  assign bus.halted     = (r_state == ST_HALT);
  assign bus.paused     = (r_state == ST_PAUSE);
  assign bus.inst_start = (r_state == ST_RUN) && (r_phase == 3'd0);
  assign bus.inst_count = r_inst_count;

endmodule
`default_nettype wire
